// File: rtl/m_icache_refill.sv
// m_icache_refill: direct-mapped instruction cache that refills a 4-word line one DRAM word at a time.
// Hits are combinational; the fill engine keeps a single DRAM request outstanding.
module m_icache_refill #(
  parameter int INDEX_BITS = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic        w_clock,
  input  logic        w_reset_n,
  input  logic [31:0] w_pc,
  input  logic        w_flush,
  output logic [31:0] w_ir,
  output logic        w_hit,
  output logic        w_mem_re,
  output logic [31:0] w_mem_addr,
  input  logic [31:0] w_mem_din,
  input  logic        w_mem_oe,
  output logic [31:0] r_miss_count
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 28 - INDEX_BITS;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
  state_t r_state, w_next;
  logic [LINES-1:0]      r_valid;
  logic [TAG_W-1:0]      r_tag [LINES];
  logic [31:0]           r_data [LINES][LINE_WORDS];
  logic [31:0]           r_fill_base;
  logic [1:0]            r_cnt;
  logic                  r_pend;
  logic [INDEX_BITS-1:0] w_idx, w_fill_idx;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_match, w_start, w_last;
  assign w_idx      = w_pc[3+INDEX_BITS:4];
  assign w_tag      = w_pc[31:4+INDEX_BITS];
  assign w_fill_idx = r_fill_base[3+INDEX_BITS:4];
  assign w_match    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  // valid stays set while a line is being replaced, so the state gate is what hides it
  assign w_hit      = (r_state == S_IDLE) && w_match && !w_flush;
  assign w_ir       = r_data[w_idx][w_pc[3:2]];
  assign w_last     = r_cnt == 2'(LINE_WORDS - 1);
  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_mem_re   = 1'b0;
    w_mem_addr = '0;
    case (r_state)
      S_IDLE: begin
        w_start = !w_flush && !w_match;
        w_next  = w_start ? S_REQ : S_IDLE;
      end
      S_REQ: begin
        w_mem_re   = 1'b1;
        w_mem_addr = r_fill_base + {28'b0, r_cnt, 2'b00};
        w_next     = S_WAIT;
      end
      S_WAIT:  w_next = w_mem_oe ? (w_last ? S_DONE : S_REQ) : S_WAIT;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) begin
      r_valid      <= '0;
      r_cnt        <= '0;
      r_pend       <= 1'b0;
      r_miss_count <= '0;
      r_fill_base  <= '0;
    end else begin
      if (w_flush) r_valid <= '0;
      else if (r_state == S_DONE && !r_pend) r_valid[w_fill_idx] <= 1'b1;
      if (r_state == S_DONE) r_pend <= 1'b0;
      else if (w_flush && r_state != S_IDLE) r_pend <= 1'b1;
      if (w_start) begin
        r_fill_base  <= w_pc & 32'hFFFF_FFF0;
        r_cnt        <= '0;
        r_miss_count <= r_miss_count + 32'd1;
      end else if (r_state == S_WAIT && w_mem_oe) begin
        r_cnt <= r_cnt + 2'd1;
      end
    end
  end
  always_ff @(posedge w_clock) begin
    if (r_state == S_WAIT && w_mem_oe) r_data[w_fill_idx][r_cnt] <= w_mem_din;
    if (r_state == S_DONE) r_tag[w_fill_idx] <= r_fill_base[31:4+INDEX_BITS];
  end
endmodule

// File: doc/m_icache_refill.md
M_ICACHE_REFILL -- requirements
Module: m_icache_refill

Interface
REQ-001 Parameter INDEX_BITS, default 4, line-index width; the cache SHALL hold 2^INDEX_BITS lines.
REQ-002 Parameter LINE_WORDS, default 4 (fixed), 32-bit words per line; word offset SHALL be w_pc[3:2].
REQ-003 Port w_clock, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 Port w_reset_n, input, 1, asynchronous active-low reset.
REQ-005 Port w_pc, input, 32, fetch address, word aligned; tag = w_pc[31:4+INDEX_BITS], index = w_pc[3+INDEX_BITS:4].
REQ-006 Port w_flush, input, 1, invalidate all lines.
REQ-007 Port w_ir, output, 32, instruction word for w_pc; valid only while w_hit=1.
REQ-008 Port w_hit, output, 1, combinational hit; the processor stalls while 0.
REQ-009 Port w_mem_re, output, 1, one-cycle word read request to DRAM.
REQ-010 Port w_mem_addr, output, 32, request word address.
REQ-011 Port w_mem_din, input, 32, DRAM read data, sampled only when w_mem_oe=1.
REQ-012 Port w_mem_oe, input, 1, DRAM data-valid strobe, one cycle per request.
REQ-013 Port r_miss_count, output, 32, number of refills started, wraps at 2^32.

Function
REQ-014 w_hit SHALL be 1 iff state=S_IDLE, valid[index]=1, stored tag[index]=tag(w_pc), and w_flush=0.
REQ-015 w_ir SHALL be data[index][w_pc[3:2]], combinational, zero-cycle latency.
REQ-016 The FSM SHALL have states S_IDLE, S_REQ, S_WAIT, S_DONE.
REQ-017 S_IDLE, w_flush=1: all valid bits SHALL clear at the edge; no refill starts that cycle.
REQ-018 S_IDLE, w_flush=0, miss: latch r_fill_base={w_pc[31:4],4'b0}, word counter to 0, increment r_miss_count, go to S_REQ.
REQ-019 S_REQ: w_mem_re=1 and w_mem_addr=r_fill_base+4*counter for exactly one cycle; then go to S_WAIT.
REQ-020 S_WAIT: w_mem_re=0; remain until w_mem_oe=1.
REQ-021 S_WAIT with w_mem_oe=1: write w_mem_din to data[fill index][counter]; if counter=3 go to S_DONE, else increment counter and go to S_REQ.
REQ-022 S_DONE: write tag of r_fill_base, set valid[fill index] unless a flush is pending, clear the pending flag, go to S_IDLE.
REQ-023 At most one DRAM request SHALL be outstanding; w_mem_re SHALL never assert in S_WAIT, S_DONE, or S_IDLE.
REQ-024 w_flush=1 in S_REQ/S_WAIT/S_DONE SHALL clear all valid bits and set a pending flag so the line being filled is left invalid.
REQ-025 A w_pc change during refill SHALL NOT abort or redirect the refill; hit is re-evaluated in S_IDLE.
REQ-026 w_mem_oe outside S_WAIT SHALL be ignored.
REQ-027 A refill into an index holding a valid line SHALL replace it; valid[index] SHALL stay 1 during the fill, with w_hit held 0 by state gating.
REQ-028 Per-word latency SHALL be 1 cycle (S_REQ) plus DRAM response time; the S_DONE-to-S_IDLE transition SHALL add 1 cycle.

Reset
REQ-029 While w_reset_n=0: state=S_IDLE, all valid bits 0, counter 0, flush-pending 0, r_miss_count 0, w_mem_re 0, w_mem_addr 0.
REQ-030 Data and tag arrays SHALL NOT require reset.
REQ-031 Reset asserted mid-refill SHALL abandon the refill with no line validated; a late w_mem_oe after reset SHALL be ignored.

Verification
REQ-032 Cold miss, w_pc=0x0, DRAM returns oe 2 cycles after re: re at cycles 1,4,7,10 with addresses 0x0,0x4,0x8,0xC; w_hit=1 at cycle 14; r_miss_count=1.
REQ-033 After REQ-032, w_pc=0x8: w_hit=1 the same cycle; w_ir equals DRAM word 2; no w_mem_re.
REQ-034 Conflict: fill 0x000, then w_pc=0x100 (same index 0): refill of 0x100-0x10C; afterwards w_pc=0x0 misses; r_miss_count=3.
REQ-035 Flush asserted during S_WAIT of word 1 for 0x40: fill completes all 4 requests; w_hit stays 0 for 0x40 after S_DONE; a new refill starts.
REQ-036 w_reset_n low for 1 cycle during S_WAIT, then a spurious w_mem_oe: state S_IDLE, no array write, r_miss_count=0, new miss refills normally.
REQ-037 w_pc changed from 0x0 to 0x20 in S_REQ of word 2: refill of 0x0 line completes, then a second refill for 0x20 starts.
